// File: rtl/regfile_pkg.sv
// Shared defaults and constants for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  // Architectural zero register: reads 0, ignores writes, never busy.
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits set at issue, cleared at writeback, with an
// incrementally tracked population count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     iss_en_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]        rd_busy_o,
  output logic [ADDR_W:0]          busy_cnt_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [Depth-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             set, clr, inc, dec;

  always_comb begin
    set    = iss_en_i && (iss_addr_i != ADDR_W'(REG_ZERO));
    clr    = wr_en_i && (wr_addr_i != ADDR_W'(REG_ZERO));
    busy_d = busy_q;
    if (clr) busy_d[wr_addr_i] = 1'b0;
    // Issue applied last so a same-cycle new producer keeps the register busy.
    if (set) busy_d[iss_addr_i] = 1'b1;

    inc   = set && !busy_q[iss_addr_i];
    dec   = clr && busy_q[wr_addr_i] && !(set && (iss_addr_i == wr_addr_i));
    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + (ADDR_W + 1)'(1);
    end else if (dec && !inc) begin
      cnt_d = cnt_q - (ADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // No same-cycle bypass: busy reflects the registered vector only.
  always_comb begin
    rd_busy_o = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_busy_o[k] = (rd_addr_i[k*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO)) &&
                     busy_q[rd_addr_i[k*ADDR_W +: ADDR_W]];
    end
  end

  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Flip-flop register file with write-through read bypass and a busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic              wr_live;

  assign wr_live = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_live) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      if (rd_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO)) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
      end else if (wr_live && (wr_addr == rd_addr[k*ADDR_W +: ADDR_W])) begin
        rd_data[k*DATA_W +: DATA_W] = wr_data;
      end else begin
        rd_data[k*DATA_W +: DATA_W] = regs_q[rd_addr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .rd_addr_i  (rd_addr),
    .rd_busy_o  (rd_busy),
    .busy_cnt_o (busy_cnt)
  );

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; depth = 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, default 2: number of independent read ports (1..4).
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port rd_addr, input, NUM_RD*ADDR_W: packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-007 Port rd_data, output, NUM_RD*DATA_W: packed combinational read data per port.
REQ-008 Port rd_busy, output, NUM_RD: scoreboard busy bit of each addressed register.
REQ-009 Port wr_en, input, 1: writeback strobe.
REQ-010 Port wr_addr, input, ADDR_W: writeback destination.
REQ-011 Port wr_data, input, DATA_W: writeback value.
REQ-012 Port iss_en, input, 1: issue strobe; marks the destination pending.
REQ-013 Port iss_addr, input, ADDR_W: issued instruction's destination register.
REQ-014 Port busy_cnt, output, ADDR_W+1: registered count of busy registers.

Function
REQ-015 Register 0 SHALL read as zero on every port, ignore writes and never become busy.
REQ-016 On wr_en with wr_addr != 0, the register SHALL take wr_data at the clock edge.
REQ-017 Reads SHALL be combinational; the bypass SHALL return wr_data when wr_en=1, wr_addr=rd_addr and rd_addr != 0.
REQ-018 Issue with iss_addr != 0 SHALL set busy[iss_addr] at the clock edge.
REQ-019 Writeback with wr_addr != 0 SHALL clear busy[wr_addr] at the clock edge.
REQ-020 Issue and writeback to the same nonzero register in one cycle SHALL leave busy set (new producer wins); data SHALL still update.
REQ-021 Issue to an already-busy register SHALL keep it busy, with no error and no count change.
REQ-022 Writeback to a non-busy register SHALL update data and leave busy clear.
REQ-023 rd_busy[k] SHALL be combinational from the current busy vector, with no bypass of same-cycle issue or writeback; for address 0 it SHALL be 0.
REQ-024 busy_cnt SHALL equal the population count of the busy vector after each edge, tracked incrementally: +1, -1 or 0 per cycle by the rules above.
REQ-025 busy_cnt SHALL never exceed 2**ADDR_W-1 or go below 0.
REQ-026 All read ports SHALL be independent; identical addresses on several ports SHALL return identical data.

Reset
REQ-027 While rst_n=0, all registers SHALL be 0, all busy bits 0 and busy_cnt 0, immediately and without a clock.
REQ-028 Reset asserted mid-operation SHALL discard pending issues; the first edge after deassertion SHALL process inputs normally.

Structure
REQ-029 Package regfile_pkg SHALL hold default DATA_W and ADDR_W and the REG_ZERO constant.
REQ-030 Busy-vector and busy_cnt logic SHALL form sub-module regfile_scoreboard; the data array and bypass SHALL stay in regfile_sb.
REQ-031 The design SHALL be flip-flop based, with no memory macro, so that asynchronous reset clears the array.

Verification
REQ-032 Reset, then read all 32 addresses on both ports -> all rd_data 0, rd_busy 0, busy_cnt 0.
REQ-033 Write 0xDEADBEEF to r5 while port0 reads r5 in the same cycle -> rd_data0=0xDEADBEEF combinationally (bypass); next cycle still 0xDEADBEEF.
REQ-034 Write 0x12345678 to r0, then read r0 -> 0; issue r0 -> busy_cnt stays 0.
REQ-035 Issue r3, then issue r7 -> busy_cnt=2, rd_busy for r3=1; writeback r3 -> busy_cnt=1, r3 not busy.
REQ-036 Busy r9; in one cycle iss_addr=9 and wr_addr=9 with 0xA5A5A5A5 -> r9=0xA5A5A5A5, busy[9]=1, busy_cnt unchanged.
REQ-037 Issue r1..r31, then drop rst_n for half a cycle -> busy_cnt=0 and r1..r31 read 0 before the next clk edge.
